// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog register slave: register offsets,
// AXI response codes and the state/select encodings.
package wdt_pkg;

  localparam logic [11:0] WDT_EN_OFF   = 12'h100;
  localparam logic [11:0] WDT_LIVE_OFF = 12'h200;
  localparam logic [11:0] WDT_CNT_OFF  = 12'h300;
  localparam logic [11:0] WDT_STAT_OFF = 12'h400;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [2:0] {
    SEL_EN,
    SEL_LIVE,
    SEL_CNT,
    SEL_STAT,
    SEL_NONE
  } reg_sel_t;

endpackage

// File: rtl/wdt_addr_dec.sv
// Combinational register-offset decode, shared by the read and write paths.
module wdt_addr_dec
  import wdt_pkg::*;
(
  input  logic [11:0] offset,
  output reg_sel_t    sel,
  output logic        dec_err
);

  always_comb begin
    sel     = SEL_NONE;
    dec_err = 1'b1;
    case (offset)
      WDT_EN_OFF:   begin sel = SEL_EN;   dec_err = 1'b0; end
      WDT_LIVE_OFF: begin sel = SEL_LIVE; dec_err = 1'b0; end
      WDT_CNT_OFF:  begin sel = SEL_CNT;  dec_err = 1'b0; end
      WDT_STAT_OFF: begin sel = SEL_STAT; dec_err = 1'b0; end
      default:      ;
    endcase
  end

endmodule

// File: rtl/wdt_reg_slave.sv
// AXI4-Lite register front-end for the watchdog core: control registers
// WDEN/WDLIVE/WTOCNT and a sticky timeout status driving wdt_irq.
module wdt_reg_slave
  import wdt_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] WTOCNT_RST = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  WTO,
  output logic                  WDEN,
  output logic                  WDLIVE,
  output logic [DATA_W-1:0]     WTOCNT,
  output logic                  wdt_irq
);

  wr_state_t             w_state, w_next;
  rd_state_t             r_state, r_next;
  logic                  accept_en;
  logic [11:0]           aw_off_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [11:0]           wr_off;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_strb;
  reg_sel_t              wr_sel, rd_sel;
  logic                  wr_err, rd_err;
  logic                  commit;
  logic [1:0]            wr_resp, rd_resp;
  logic                  upd_en, upd_cnt, live_set, stat_clr;
  logic [DATA_W-1:0]     rd_data;
  logic                  unused_addr;

  assign unused_addr = ^{AWADDR[ADDR_W-1:12], ARADDR[ADDR_W-1:12]};

  // Ready outputs stay low while in reset and for the first cycle after it.
  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: if (accept_en) begin
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        if (AWVALID && WVALID) w_next = W_RESP;
        else if (AWVALID)      w_next = W_HAVE_AW;
        else if (WVALID)       w_next = W_HAVE_W;
      end
      W_HAVE_AW: begin
        WREADY = 1'b1;
        if (WVALID) w_next = W_RESP;
      end
      W_HAVE_W: begin
        AWREADY = 1'b1;
        if (AWVALID) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign commit = (w_state != W_RESP) && (w_next == W_RESP);

  // Whichever half arrives on the committing edge is taken straight from the bus.
  assign wr_off  = (w_state == W_HAVE_AW) ? aw_off_q : AWADDR[11:0];
  assign wr_data = (w_state == W_HAVE_W)  ? wdata_q  : WDATA;
  assign wr_strb = (w_state == W_HAVE_W)  ? wstrb_q  : WSTRB;

  wdt_addr_dec u_wr_dec (.offset(wr_off),       .sel(wr_sel), .dec_err(wr_err));
  wdt_addr_dec u_rd_dec (.offset(ARADDR[11:0]), .sel(rd_sel), .dec_err(rd_err));

  always_comb begin
    wr_resp  = RESP_OKAY;
    upd_en   = 1'b0;
    upd_cnt  = 1'b0;
    live_set = 1'b0;
    stat_clr = 1'b0;
    if (wr_err) begin
      wr_resp = RESP_DECERR;
    end else begin
      case (wr_sel)
        SEL_EN:   upd_en   = wr_strb[0];
        SEL_LIVE: live_set = wr_strb[0] & wr_data[0];
        SEL_CNT:  if (WDEN) wr_resp = RESP_SLVERR;
                  else      upd_cnt = 1'b1;
        SEL_STAT: stat_clr = wr_strb[0] & wr_data[0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      accept_en <= 1'b0;
      aw_off_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      BRESP     <= RESP_OKAY;
      WDEN      <= 1'b0;
      WDLIVE    <= 1'b0;
      WTOCNT    <= WTOCNT_RST;
      wdt_irq   <= 1'b0;
    end else begin
      w_state   <= w_next;
      accept_en <= 1'b1;
      if (AWREADY && AWVALID) aw_off_q <= AWADDR[11:0];
      if (WREADY && WVALID) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      WDLIVE  <= commit & live_set;
      wdt_irq <= WTO | (wdt_irq & ~(commit & stat_clr));
      if (commit) begin
        BRESP <= wr_resp;
        if (upd_en) WDEN <= wr_data[0];
        if (upd_cnt) begin
          for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            if (wr_strb[i]) WTOCNT[i*8 +: 8] <= wr_data[i*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = accept_en;
        if (accept_en && ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = rd_err ? RESP_DECERR : RESP_OKAY;
    case (rd_sel)
      SEL_EN:   rd_data[0] = WDEN;
      SEL_CNT:  rd_data    = WTOCNT;
      SEL_STAT: rd_data[0] = wdt_irq;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ARREADY && ARVALID) begin
        RDATA <= rd_data;
        RRESP <= rd_resp;
      end
    end
  end

endmodule

// File: doc/wdt_reg_slave.md
Name: wdt_reg_slave

Overview:
AXI4-Lite slave register front-end for the watchdog timer core. Decodes CPU writes into the WDEN, WDLIVE and WTOCNT control inputs that drive the core directly downstream. Captures the core's WTO output into a sticky status bit and raises an interrupt request to the CPU. Runs in one clock domain with the core; no CDC.

Parameters:
ADDR_W, 32, AXI address width; only ADDR[11:0] decoded
DATA_W, 32, AXI data width; fixed 32
WTOCNT_RST, 32'd0, reset value of WTOCNT register

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
AWADDR  in  ADDR_W  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response (00 OKAY, 10 SLVERR, 11 DECERR)
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
WTO  in  1  timeout from watchdog core
WDEN  out  1  enable to core
WDLIVE  out  1  kick to core
WTOCNT  out  32  timeout count to core
wdt_irq  out  1  interrupt = sticky timeout status

Behaviour:
- Reset (async, rst=1): all outputs 0 except WTOCNT=WTOCNT_RST. Registers cleared. Any outstanding transaction is dropped; no response is issued for it.
- Register map (ADDR[11:0]):
  - 0x100 WDEN, bit0 RW.
  - 0x200 WDLIVE, bit0, write-only; reads return 0.
  - 0x300 WTOCNT, 32-bit RW, byte strobes honoured.
  - 0x400 STATUS, bit0 = sticky WTO, write-1-to-clear.
  - Any other offset: DECERR, no side effect, RDATA=0.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: AWREADY=1, WREADY=1. Both handshake in the same cycle → W_RESP. AW only → W_HAVE_AW. W only → W_HAVE_W.
  - W_HAVE_AW: WREADY=1 only. W handshake → W_RESP.
  - W_HAVE_W: AWREADY=1 only. AW handshake → W_RESP.
  - Register update occurs on the edge entering W_RESP, so new values are visible on core outputs the following cycle.
  - W_RESP: BVALID=1, BRESP held stable until BREADY; then → W_IDLE.
- WSTRB[0]=0 on a 1-bit register: no change, OKAY.
- WTOCNT write while WDEN=1: ignored, BRESP=SLVERR. Writing WDEN=0 is always allowed.
- WDLIVE: a write with WSTRB[0]=1 and WDATA[0]=1 drives WDLIVE=1 for exactly one cycle (the cycle after the update edge), then auto-clears. Writing 0 has no effect.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On handshake, RDATA/RRESP are registered → R_DATA.
  - R_DATA: RVALID=1, held until RREADY → R_IDLE.
  - Read latency: RVALID one cycle after the AR handshake.
- Read and write channels are independent. If a read samples a register on the same edge it is written, RDATA returns the old value.
- Sticky status: set on any cycle with WTO=1. If set and a W1C clear coincide, set wins. wdt_irq = status bit, no extra latency.

Decomposition:
- Shared package wdt_pkg:
  - Offset constants WDT_EN_OFF, WDT_LIVE_OFF, WDT_CNT_OFF, WDT_STAT_OFF.
  - AXI resp localparams RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - Enums wr_state_t and rd_state_t.
- One natural sub-module: wdt_addr_dec. Combinational offset decode returning a register select and decode-error flag; shared by the read and write paths.

Test Plan:
- Write 0x300=0x0000_0010 with WSTRB=F, then 0x100=1 → both BRESP=OKAY. WTOCNT=0x10 and WDEN=1 one cycle after each W_RESP entry. Read 0x300 → 0x10.
- With WDEN=1, write 0x300=0x20 → BRESP=SLVERR; WTOCNT stays 0x10.
- Write 0x200=1 → WDLIVE high exactly 1 cycle. Read 0x200 → 0.
- Drive WTO=1 one cycle → wdt_irq=1 next cycle, read 0x400 → 1. Write 0x400=1 with WTO=0 → cleared. Repeat the clear with WTO=1 in the same cycle → stays 1.
- AW two cycles before W, and separately W before AW, with BREADY low 3 cycles → BVALID held and BRESP stable until BREADY. Access to 0x500 → DECERR, RDATA=0.
- Assert rst mid-transaction (in W_HAVE_AW) → all outputs 0 immediately. After reset release, a fresh write completes normally.
